// File: rtl/uart_pkg.sv
// Shared types and constants for the UART program loader.
// Holds the loader state encoding and the byte-lane arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_ERR
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE  = 8'hA5;
  localparam int         DEFAULT_BYTE_WIDTH = 8;
  localparam int         DEFAULT_DATA_WIDTH = 32;
  localparam int         DEFAULT_LANES      = DEFAULT_DATA_WIDTH / DEFAULT_BYTE_WIDTH;

  function automatic int lane_count(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs consecutive bytes little-endian into a word and keeps a running XOR
// checksum; word_valid pulses the cycle after the final lane byte.
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic                  last_lane,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word,
  output logic [BYTE_WIDTH-1:0] checksum
);

  localparam int LANES  = lane_count(DATA_WIDTH, BYTE_WIDTH);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANE_W-1:0]     lane_reg;
  logic [DATA_WIDTH-1:0] word_reg;
  logic                  word_valid_reg;
  logic [BYTE_WIDTH-1:0] checksum_reg;

  assign last_lane  = (lane_reg == LANE_W'(LANES - 1));
  assign word_valid = word_valid_reg;
  assign word       = word_reg;
  assign checksum   = checksum_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lane_reg       <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      checksum_reg   <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clear) begin
        lane_reg     <= '0;
        checksum_reg <= '0;
      end else if (byte_valid) begin
        // Shift right so the first byte of a word ends up in lane 0.
        word_reg       <= (word_reg >> BYTE_WIDTH) |
                          (DATA_WIDTH'(byte_in) << (DATA_WIDTH - BYTE_WIDTH));
        checksum_reg   <= checksum_reg ^ byte_in;
        lane_reg       <= last_lane ? '0 : lane_reg + 1'b1;
        word_valid_reg <= last_lane;
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Packet parser that loads a program image over UART into instruction memory
// and gates CPU run control on a checksum-verified load.
module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int              BYTE_WIDTH     = DEFAULT_BYTE_WIDTH,
  parameter int              DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int              ADDR_WIDTH     = 8,
  parameter logic [7:0]      SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int              TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx_done,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  cpu_run
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t         state_reg, state_next;
  logic [7:0]            len_reg;
  logic [ADDR_WIDTH-1:0] word_cnt_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic                  cpu_run_reg, cpu_run_next;
  logic                  load_err_reg, load_err_next;
  logic                  load_busy_reg, load_busy_next;
  logic                  load_done_reg, load_done_next;

  logic                  start, active, timed_out, byte_valid, last_lane;
  logic [BYTE_WIDTH-1:0] checksum;

  assign start      = (state_reg == ST_IDLE) && rx_done && (rx_data == SYNC_BYTE);
  assign active     = (state_reg == ST_LEN) || (state_reg == ST_DATA) || (state_reg == ST_CHK);
  assign timed_out  = active && !rx_done && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign byte_valid = (state_reg == ST_DATA) && rx_done;

  uart_word_assembler #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk       (clk),
    .arst_n    (arst_n),
    .clear     (start),
    .byte_valid(byte_valid),
    .byte_in   (rx_data),
    .last_lane (last_lane),
    .word_valid(mem_we),
    .word      (mem_wdata),
    .checksum  (checksum)
  );

  assign mem_addr  = mem_addr_reg;
  assign load_busy = load_busy_reg;
  assign load_done = load_done_reg;
  assign load_err  = load_err_reg;
  assign cpu_run   = cpu_run_reg;

  always_comb begin
    state_next     = state_reg;
    cpu_run_next   = cpu_run_reg;
    load_err_next  = load_err_reg;
    load_busy_next = load_busy_reg;
    load_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_LEN;
          cpu_run_next   = 1'b0;
          load_err_next  = 1'b0;
          load_busy_next = 1'b1;
        end
      end
      ST_LEN: begin
        if (timed_out) state_next = ST_ERR;
        else if (rx_done) state_next = (rx_data == '0) ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (timed_out) state_next = ST_ERR;
        else if (rx_done && last_lane && (word_cnt_reg == ADDR_WIDTH'(len_reg - 8'd1)))
          state_next = ST_CHK;
      end
      ST_CHK: begin
        if (timed_out) state_next = ST_ERR;
        else if (rx_done) begin
          if (rx_data == checksum) begin
            state_next     = ST_IDLE;
            load_done_next = 1'b1;
            cpu_run_next   = 1'b1;
            load_busy_next = 1'b0;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Every path into ERR raises the sticky flag on the transition edge.
    if (state_next == ST_ERR) begin
      load_err_next  = 1'b1;
      load_busy_next = 1'b0;
      cpu_run_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      word_cnt_reg  <= '0;
      mem_addr_reg  <= '0;
      to_cnt_reg    <= '0;
      cpu_run_reg   <= 1'b0;
      load_err_reg  <= 1'b0;
      load_busy_reg <= 1'b0;
      load_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cpu_run_reg   <= cpu_run_next;
      load_err_reg  <= load_err_next;
      load_busy_reg <= load_busy_next;
      load_done_reg <= load_done_next;
      if (state_reg == ST_LEN && rx_done) len_reg <= rx_data;
      if (start) begin
        word_cnt_reg <= '0;
      end else if (byte_valid && last_lane) begin
        mem_addr_reg <= word_cnt_reg;
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end
      if (active && !rx_done) to_cnt_reg <= to_cnt_reg + 1'b1;
      else to_cnt_reg <= '0;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: table of packets plus hand-written
// sequences for zero length, timeout and mid-packet reset.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        load_busy, load_done, load_err, cpu_run;

  always #5 clk = ~clk;

  uart_prog_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err (load_err),
    .cpu_run  (cpu_run)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (load_done) done_cnt++;
  end

  typedef struct {
    string       name;
    logic [7:0]  b[$];
    int          gap;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          done;
    logic        err;
    logic        run;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    int base_w, base_d;
    logic [31:0] expw;
    base_w = wr_addr_q.size();
    base_d = done_cnt;
    for (int j = 0; j < vecs[i].b.size(); j++) send_byte(vecs[i].b[j], vecs[i].gap);
    repeat (4) @(negedge clk);
    chk({vecs[i].name, "_nwrites"}, 64'(wr_addr_q.size() - base_w), 64'(vecs[i].nw));
    for (int k = 0; k < vecs[i].nw && base_w + k < wr_addr_q.size(); k++) begin
      expw = (k == 0) ? vecs[i].w0 : vecs[i].w1;
      chk({vecs[i].name, "_addr"}, 64'(wr_addr_q[base_w + k]), 64'(k));
      chk({vecs[i].name, "_data"}, 64'(wr_data_q[base_w + k]), 64'(expw));
    end
    chk({vecs[i].name, "_done"}, 64'(done_cnt - base_d), 64'(vecs[i].done));
    chk({vecs[i].name, "_err"}, 64'(load_err), 64'(vecs[i].err));
    chk({vecs[i].name, "_run"}, 64'(cpu_run), 64'(vecs[i].run));
    chk({vecs[i].name, "_busy"}, 64'(load_busy), 64'd0);
    $display("[TB] packet %s: %0d writes, done=%0d err=%0b run=%0b", vecs[i].name,
             wr_addr_q.size() - base_w, done_cnt - base_d, load_err, cpu_run);
  endtask

  initial begin
    int base_w, n;

    vecs[0].name = "happy";
    vecs[0].b    = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
    vecs[0].gap  = 1; vecs[0].nw = 2; vecs[0].w0 = 32'h11223344; vecs[0].w1 = 32'hAABBCCDD;
    vecs[0].done = 1; vecs[0].err = 1'b0; vecs[0].run = 1'b1;

    vecs[1].name = "badchk";
    vecs[1].b    = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h45};
    vecs[1].gap  = 1; vecs[1].nw = 2; vecs[1].w0 = 32'h11223344; vecs[1].w1 = 32'hAABBCCDD;
    vecs[1].done = 0; vecs[1].err = 1'b1; vecs[1].run = 1'b0;

    vecs[2].name = "b2b";
    vecs[2].b    = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
    vecs[2].gap  = 0; vecs[2].nw = 2; vecs[2].w0 = 32'h11223344; vecs[2].w1 = 32'hAABBCCDD;
    vecs[2].done = 1; vecs[2].err = 1'b0; vecs[2].run = 1'b1;

    // Sync value appearing as length-region data and payload is plain data.
    vecs[3].name = "syncdata";
    vecs[3].b    = '{8'hA5, 8'h01, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[3].gap  = 2; vecs[3].nw = 1; vecs[3].w0 = 32'hA50000A5; vecs[3].w1 = 32'h0;
    vecs[3].done = 1; vecs[3].err = 1'b0; vecs[3].run = 1'b1;

    arst_n  = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({mem_we, mem_addr, mem_wdata, load_busy, load_done, load_err, cpu_run}), 64'd0);
    arst_n = 1'b1;
    @(negedge clk);

    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 1);
    chk("noise_busy", 64'(load_busy), 64'd0);
    chk("noise_run", 64'(cpu_run), 64'd0);
    $display("[TB] noise bytes: busy=%0b", load_busy);

    for (int i = 0; i < 4; i++) run_vec(i);

    base_w = wr_addr_q.size();
    send_byte(8'hA5, 0);
    chk("zl_busy_on_sync", 64'(load_busy), 64'd1);
    chk("zl_run_cleared", 64'(cpu_run), 64'd0);
    send_byte(8'h00, 0);
    chk("zl_err_latency", 64'(load_err), 64'd1);
    chk("zl_busy", 64'(load_busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("zl_nwrites", 64'(wr_addr_q.size() - base_w), 64'd0);
    chk("zl_err_sticky", 64'(load_err), 64'd1);
    $display("[TB] zero length: err=%0b", load_err);

    base_w = wr_addr_q.size();
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    n = 0;
    while (!load_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 64'(n), 64'd100);
    chk("to_err", 64'(load_err), 64'd1);
    chk("to_busy", 64'(load_busy), 64'd0);
    chk("to_nwrites", 64'(wr_addr_q.size() - base_w), 64'd0);
    $display("[TB] timeout: err after %0d idle cycles", n);
    repeat (2) @(negedge clk);
    send_byte(8'hA5, 0);
    chk("to_err_cleared", 64'(load_err), 64'd0);
    chk("to_busy_restart", 64'(load_busy), 64'd1);
    @(negedge clk);
    vecs[0].b.delete(0);
    run_vec(0);
    vecs[0].b.push_front(8'hA5);

    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h44, 1);
    send_byte(8'h33, 1);
    send_byte(8'h22, 1);
    chk("rst_busy_before", 64'(load_busy), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({mem_we, mem_addr, mem_wdata, load_busy, load_done, load_err, cpu_run}), 64'd0);
    $display("[TB] mid-packet reset: busy=%0b wdata=%0h", load_busy, mem_wdata);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
